mem_port_arbiter: RTL

Arbiter and sequencer for the single shared memory port of the MIPS pipeline. It serialises instruction-fetch (IF stage) and data-memory (MEM stage) accesses onto one fixed-latency memory. It drives stall signals back to the pipeline while an access is outstanding. Data accesses have priority; a starvation guard guarantees forward progress for fetch.

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shared memory-port arbiter: serialises IF fetches and MEM-stage data accesses
// onto one fixed-latency memory. Data wins ties unless fetch has been starved.
module mem_port_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        stall_if,
    output logic        stall_mem
);
    localparam int LW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [LW-1:0] LAT  = LW'(MEM_LAT);
    localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic          owner;      // 1 = data port, 0 = fetch port
    logic [LW-1:0] lat_cnt;
    logic [SW-1:0] starve_cnt;
    logic          grant_dm;

    // Data has priority except when fetch has lost STARVE_LIMIT grants in a row.
    always_comb grant_dm = dm_req & ~(if_req & (starve_cnt == SLIM));

    assign stall_if  = if_req & ~if_ready;
    assign stall_mem = dm_req & ~dm_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        owner    <= grant_dm;
                        mem_en   <= 1'b1;
                        mem_we   <= grant_dm & dm_we;
                        mem_addr <= grant_dm ? dm_addr : if_addr;
                        if (grant_dm)
                            mem_wdata <= dm_wdata;
                        if (grant_dm && if_req)
                            starve_cnt <= (starve_cnt == SLIM) ? SLIM : starve_cnt + 1'b1;
                        else
                            starve_cnt <= '0;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en  <= 1'b0;
                    lat_cnt <= LAT;
                    state   <= WAIT;
                end
                WAIT: begin
                    lat_cnt <= lat_cnt - 1'b1;
                    if (lat_cnt == LW'(1)) begin
                        if (owner) begin
                            if (!mem_we)
                                dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    if_ready <= 1'b0;
                    dm_ready <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
